// File: rtl/aurora_flow_monitor_core_if.sv
// Input-side bundle of the Aurora flow monitor: core status, FIFO flags,
// AXI-Stream handshakes and the CRC result strobe.
interface aurora_flow_monitor_core_if;
  logic [12:0] aurora_status;
  logic        fifo_rx_almost_full;
  logic        fifo_tx_almost_full;
  logic        tx_tvalid, tx_tready;
  logic        rx_tvalid, rx_tready;
  logic        crc_valid;
  logic        crc_pass_fail_n;

  modport master (
    output aurora_status, fifo_rx_almost_full, fifo_tx_almost_full,
           tx_tvalid, tx_tready, rx_tvalid, rx_tready, crc_valid, crc_pass_fail_n
  );
  modport slave (
    input  aurora_status, fifo_rx_almost_full, fifo_tx_almost_full,
           tx_tvalid, tx_tready, rx_tvalid, rx_tready, crc_valid, crc_pass_fail_n
  );
endinterface

// File: rtl/aurora_flow_monitor_core.sv
// Aurora 64B66B link statistics: 19 free-running level-event counters.
// Optional macro AURORA_MONITOR_SATURATE_EN: counters hold at all-ones instead of wrapping.

module aurora_flow_monitor_cnt_nxt #(
  parameter int CNT_W = 32
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] nxt_o
);
  always_comb begin
    nxt_o = cnt_i;
`ifdef AURORA_MONITOR_SATURATE_EN
    if (inc_i && (cnt_i != {CNT_W{1'b1}})) nxt_o = cnt_i + 1'b1;
`else
    if (inc_i) nxt_o = cnt_i + 1'b1;
`endif
  end
endmodule

module aurora_flow_monitor_core #(
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aurora_flow_monitor_core_if.slave bus,
  output logic [CNT_W-1:0]          gt_not_ready_0_count,
  output logic [CNT_W-1:0]          gt_not_ready_1_count,
  output logic [CNT_W-1:0]          gt_not_ready_2_count,
  output logic [CNT_W-1:0]          gt_not_ready_3_count,
  output logic [CNT_W-1:0]          line_down_0_count,
  output logic [CNT_W-1:0]          line_down_1_count,
  output logic [CNT_W-1:0]          line_down_2_count,
  output logic [CNT_W-1:0]          line_down_3_count,
  output logic [CNT_W-1:0]          pll_not_locked_count,
  output logic [CNT_W-1:0]          mmcm_not_locked_count,
  output logic [CNT_W-1:0]          hard_err_count,
  output logic [CNT_W-1:0]          soft_err_count,
  output logic [CNT_W-1:0]          channel_down_count,
  output logic [CNT_W-1:0]          fifo_rx_overflow_count,
  output logic [CNT_W-1:0]          fifo_tx_overflow_count,
  output logic [CNT_W-1:0]          tx_count,
  output logic [CNT_W-1:0]          rx_count,
  output logic [CNT_W-1:0]          frames_received,
  output logic [CNT_W-1:0]          frames_with_errors
);
  localparam int NUM_CNT = 19;

  logic [NUM_CNT-1:0]            inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Index map: [3:0] gt lanes, [7:4] line lanes, 8 pll, 9 mmcm, 10 hard, 11 soft,
  // 12 chan down, 13/14 fifo rx/tx, 15/16 tx/rx beats, 17 frames, 18 crc fails.
  always_comb begin
    inc = '0;
    inc[3:0] = ~bus.aurora_status[3:0];
    inc[7:4] = ~bus.aurora_status[7:4];
    inc[8]   = ~bus.aurora_status[8];
    inc[9]   =  bus.aurora_status[9];
    inc[10]  =  bus.aurora_status[10];
    inc[11]  =  bus.aurora_status[11];
    inc[12]  = ~bus.aurora_status[12];
    inc[13]  =  bus.fifo_rx_almost_full;
    inc[14]  =  bus.fifo_tx_almost_full;
    inc[15]  =  bus.tx_tvalid & bus.tx_tready;
    inc[16]  =  bus.rx_tvalid & bus.rx_tready;
    inc[17]  =  bus.crc_valid;
    inc[18]  =  bus.crc_valid & ~bus.crc_pass_fail_n;
  end

  aurora_flow_monitor_cnt_nxt #(.CNT_W(CNT_W)) u_nxt [NUM_CNT-1:0] (
    .cnt_i (cnt_q),
    .inc_i (inc),
    .nxt_o (cnt_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign gt_not_ready_0_count   = cnt_q[0];
  assign gt_not_ready_1_count   = cnt_q[1];
  assign gt_not_ready_2_count   = cnt_q[2];
  assign gt_not_ready_3_count   = cnt_q[3];
  assign line_down_0_count      = cnt_q[4];
  assign line_down_1_count      = cnt_q[5];
  assign line_down_2_count      = cnt_q[6];
  assign line_down_3_count      = cnt_q[7];
  assign pll_not_locked_count   = cnt_q[8];
  assign mmcm_not_locked_count  = cnt_q[9];
  assign hard_err_count         = cnt_q[10];
  assign soft_err_count         = cnt_q[11];
  assign channel_down_count     = cnt_q[12];
  assign fifo_rx_overflow_count = cnt_q[13];
  assign fifo_tx_overflow_count = cnt_q[14];
  assign tx_count               = cnt_q[15];
  assign rx_count               = cnt_q[16];
  assign frames_received        = cnt_q[17];
  assign frames_with_errors     = cnt_q[18];
endmodule

// File: tb/tb_aurora_flow_monitor_core.sv
// Directed bench for aurora_flow_monitor_core: every counter checked against a
// hand-maintained expected table after each stimulus step.
module tb_aurora_flow_monitor_core;
  localparam int CNT_W = 32;
  localparam int NUM_CNT = 19;
  localparam logic [12:0] CORE_STATUS_OK  = 13'h11FF;
  localparam logic [12:0] GT_POWERGOOD    = 13'h000F;
  localparam logic [12:0] LINE_UP         = 13'h00F0;
  localparam logic [12:0] GT_PLL_LOCK     = 13'h0100;
  localparam logic [12:0] MMCM_NOT_LOCKED = 13'h0200;
  localparam logic [12:0] HARD_ERR        = 13'h0400;
  localparam logic [12:0] SOFT_ERR        = 13'h0800;
  localparam logic [12:0] CHANNEL_UP      = 13'h1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aurora_flow_monitor_core_if bus();

  logic [CNT_W-1:0] got [NUM_CNT];
  logic [CNT_W-1:0] exp_c [NUM_CNT];
  int n_chk = 0;
  int n_pass = 0;

  aurora_flow_monitor_core #(.CNT_W(CNT_W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus                    (bus),
    .gt_not_ready_0_count   (got[0]),
    .gt_not_ready_1_count   (got[1]),
    .gt_not_ready_2_count   (got[2]),
    .gt_not_ready_3_count   (got[3]),
    .line_down_0_count      (got[4]),
    .line_down_1_count      (got[5]),
    .line_down_2_count      (got[6]),
    .line_down_3_count      (got[7]),
    .pll_not_locked_count   (got[8]),
    .mmcm_not_locked_count  (got[9]),
    .hard_err_count         (got[10]),
    .soft_err_count         (got[11]),
    .channel_down_count     (got[12]),
    .fifo_rx_overflow_count (got[13]),
    .fifo_tx_overflow_count (got[14]),
    .tx_count               (got[15]),
    .rx_count               (got[16]),
    .frames_received        (got[17]),
    .frames_with_errors     (got[18])
  );

  task automatic chk(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < NUM_CNT; i++) chk($sformatf("%s[%0d]", tag, i), got[i], exp_c[i]);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input int lo, input int hi, input int v);
    for (int i = lo; i <= hi; i++) exp_c[i] = exp_c[i] + CNT_W'(v);
  endtask

  task automatic status_pulse(input logic [12:0] mask, input string tag);
    bus.aurora_status = CORE_STATUS_OK ^ mask;
    cyc(3);
    bus.aurora_status = CORE_STATUS_OK;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.aurora_status = CORE_STATUS_OK;
    bus.fifo_rx_almost_full = 1'b0;
    bus.fifo_tx_almost_full = 1'b0;
    bus.tx_tvalid = 1'b0; bus.tx_tready = 1'b0;
    bus.rx_tvalid = 1'b0; bus.rx_tready = 1'b0;
    bus.crc_valid = 1'b0; bus.crc_pass_fail_n = 1'b1;
    for (int i = 0; i < NUM_CNT; i++) exp_c[i] = '0;

    cyc(2);
    chk_all("reset");
    rst_n = 1'b1;
    cyc(1);
    chk_all("idle");

    add(0, 3, 3);  status_pulse(GT_POWERGOOD,    "gt_not_ready");
    add(4, 7, 3);  status_pulse(LINE_UP,         "line_down");
    add(8, 8, 3);  status_pulse(GT_PLL_LOCK,     "pll");
    add(9, 9, 3);  status_pulse(MMCM_NOT_LOCKED, "mmcm");
    add(10, 10, 3); status_pulse(HARD_ERR,       "hard_err");
    add(11, 11, 3); status_pulse(SOFT_ERR,       "soft_err");
    add(12, 12, 3); status_pulse(CHANNEL_UP,     "chan_down");

    for (int i = 0; i < 4; i++) begin bus.fifo_rx_almost_full = ~i[0]; cyc(1); end
    for (int i = 0; i < 6; i++) begin bus.fifo_tx_almost_full = ~i[0]; cyc(1); end
    add(13, 13, 2); add(14, 14, 3);
    chk_all("fifo");

    bus.crc_valid = 1'b1;
    bus.crc_pass_fail_n = 1'b1; cyc(4);
    bus.crc_pass_fail_n = 1'b0; cyc(1);
    bus.crc_valid = 1'b0;       cyc(1);
    bus.crc_valid = 1'b1; bus.crc_pass_fail_n = 1'b1; cyc(1);
    bus.crc_valid = 1'b0;
    add(17, 17, 6); add(18, 18, 1);
    chk_all("crc");

    // fail flag with no strobe must be ignored
    bus.crc_pass_fail_n = 1'b0; cyc(2); bus.crc_pass_fail_n = 1'b1;
    chk_all("crc_idle");

    bus.tx_tvalid = 1'b1; bus.tx_tready = 1'b1;
    bus.rx_tvalid = 1'b1; bus.rx_tready = 1'b1;
    cyc(3);
    bus.tx_tvalid = 1'b0;
    cyc(2);
    bus.rx_tvalid = 1'b0; bus.rx_tready = 1'b0;
    add(15, 15, 3); add(16, 16, 5);
    chk_all("axis");

    // half handshakes: tx ready-only, rx valid-only
    bus.rx_tvalid = 1'b1; cyc(2);
    bus.rx_tvalid = 1'b0; bus.tx_tready = 1'b0;
    chk_all("axis_half");

    // everything at once for one edge
    bus.aurora_status = 13'h0000;
    bus.fifo_rx_almost_full = 1'b1; bus.fifo_tx_almost_full = 1'b1;
    bus.tx_tvalid = 1'b1; bus.tx_tready = 1'b1;
    bus.rx_tvalid = 1'b1; bus.rx_tready = 1'b1;
    bus.crc_valid = 1'b1; bus.crc_pass_fail_n = 1'b0;
    cyc(1);
    bus.aurora_status = CORE_STATUS_OK;
    bus.fifo_rx_almost_full = 1'b0; bus.fifo_tx_almost_full = 1'b0;
    bus.tx_tvalid = 1'b0; bus.tx_tready = 1'b0;
    bus.rx_tvalid = 1'b0; bus.rx_tready = 1'b0;
    bus.crc_valid = 1'b0; bus.crc_pass_fail_n = 1'b1;
    add(0, 8, 1); add(12, 18, 1);
    chk_all("simul");

    // preload all counters to all-ones, then one tx beat
    force dut.cnt_q = '1;
    #1;
    release dut.cnt_q;
    for (int i = 0; i < NUM_CNT; i++) exp_c[i] = '1;
    bus.tx_tvalid = 1'b1; bus.tx_tready = 1'b1;
    cyc(1);
    bus.tx_tvalid = 1'b0; bus.tx_tready = 1'b0;
`ifdef AURORA_MONITOR_SATURATE_EN
    exp_c[15] = '1;
`else
    exp_c[15] = '0;
`endif
    chk_all("wrap");

    // asynchronous clear away from any clock edge
    bus.rx_tvalid = 1'b1; bus.rx_tready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_CNT; i++) exp_c[i] = '0;
    chk_all("async_rst");
    cyc(1);
    bus.rx_tvalid = 1'b0; bus.rx_tready = 1'b0;
    chk_all("rst_hold");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
